mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single-port dummy memory model among NREQ requesters
//  (e.g. instruction fetch and load/store). Accepts per-requester read/write requests,
//  sequences the memory's req/memBusy handshake, and returns read data with a done pulse.
//  Sits between the core-side masters and the memory; exactly one transaction is in flight.
// PARAMETERS
//  NREQ           2    number of requesters (>=2)
//  ADDR_W         32   address width (default `MEM_ADDR_SIZE)
//  DATA_W         8    data word width (default `MEM_WORD_SIZE)
//  ISSUE_TIMEOUT  16   max cycles in ISSUE waiting for memBusy; 0 disables the timeout
// PORTS
//  clk        in   1             clock, all state on posedge
//  reset      in   1             asynchronous, active-high reset
//  reqIn      in   NREQ          per-requester request level; held until its done/err
//  reqWr      in   NREQ          1=write, 0=read; sampled at grant
//  reqAddr    in   NREQ*ADDR_W   flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//  reqWData   in   NREQ*DATA_W   flattened write data, same packing
//  grant      out  NREQ          one-hot, winner held from accept until done/err cycle
//  done       out  NREQ          one-cycle pulse per requester: transaction complete
//  err        out  NREQ          one-cycle pulse: ISSUE timeout, transaction aborted
//  rData      out  DATA_W        read data, valid in the done cycle, held until next read
//  memReq     out  1             to memory req
//  memWr      out  1             to memory wr
//  memAddr    out  ADDR_W        to memory address
//  memDataIn  out  DATA_W        to memory write data
//  memBusy    in   1             from memory
//  memDataOut in   DATA_W        from memory read data
// BEHAVIOUR
//  Reset: all outputs 0, state ARB_IDLE, lastGrant=NREQ-1 (requester 0 wins first), timer 0.
//  Reset mid-transaction aborts silently: no done/err pulse, memReq drops immediately.
//  FSM (registered outputs):
//   ARB_IDLE : if |reqIn: winner = first set bit searching from lastGrant+1 mod NREQ;
//              latch wr/addr/wdata to memWr/memAddr/memDataIn; grant=onehot(winner);
//              memReq=1; timer=0 -> ARB_ISSUE. Else stay, memReq=0.
//   ARB_ISSUE: memBusy=1 -> memReq=0 -> ARB_WAIT. Else timer++; if ISSUE_TIMEOUT!=0 and
//              timer==ISSUE_TIMEOUT-1 -> memReq=0, err[winner]=1 -> ARB_DONE.
//   ARB_WAIT : memBusy=0 -> if !memWr rData=memDataOut; done[winner]=1 -> ARB_DONE.
//              No timeout here (memory latency is unbounded by design).
//   ARB_DONE : grant=0, done/err=0, lastGrant=winner -> ARB_IDLE. Gap cycle matches the
//              memory READY state; no new req is issued while memory is returning to IDLE.
//  memAddr/memWr/memDataIn stay stable from ARB_IDLE accept through ARB_WAIT exit.
//  Zero-latency memory: reqIn sampled at edge0 -> done visible after edge3 (4 cycles);
//  next accept earliest at edge5. Requester drops reqIn in the cycle after done, else it
//  re-competes (round-robin still favours others).
//  Requests changing while granted are ignored; reqIn dropping before done is a protocol
//  violation -- the transaction still completes and done still pulses.
//  Only the winner's bit is ever set in grant/done/err; done and err never both pulse.
// STRUCTURE
//  Shared header mem_arb_defs.vh: ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_DONE encodings (2 bits),
//  default-width macros reused from the memory header.
//  Sub-module rr_picker (combinational): inputs reqIn, lastGrant; outputs winner index and
//  valid. Rotate, priority-encode, un-rotate; pure function of inputs.
// TESTING
//  1 Single read: mem[5]=8'hA5, reqIn=01 addr 5 -> grant=01, done=01 after 4 cycles, rData=A5.
//  2 Write then read: req0 writes 8'h3C to addr 7, then req1 reads addr 7 -> rData=3C.
//  3 Contention: reqIn=11 held -> grants alternate 01,10,01,10; no requester starved.
//  4 Latency: USE_MEM_LATENCY, RD_LATENCY=10 -> grant held, memAddr stable, single done.
//  5 Timeout: memBusy forced 0, ISSUE_TIMEOUT=16 -> err[winner] pulse 16 cycles after accept.
//  6 Reset mid-WAIT: all outputs 0, no done; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared state encodings and default widths for the memory arbiter.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_SIZE = 32;
    localparam int MEM_WORD_SIZE = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module mem_arbiter_rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int unsigned       base;
    int unsigned       pos;

    always_comb begin
        base  = 32'(last) + 32'd1;
        dbl   = {req, req} >> base;
        rot   = dbl[NREQ-1:0];
        pos   = 0;
        valid = 1'b0;
        // Scan downwards so the lowest rotated index wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos   = i;
                valid = 1'b1;
            end
        end
        winner = IW'((base + pos) % NREQ);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NREQ masters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int ADDR_W        = MEM_ADDR_SIZE,
    parameter int DATA_W        = MEM_WORD_SIZE,
    parameter int ISSUE_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          reqIn,
    input  logic [NREQ-1:0]          reqWr,
    input  logic [NREQ*ADDR_W-1:0]   reqAddr,
    input  logic [NREQ*DATA_W-1:0]   reqWData,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          done,
    output logic [NREQ-1:0]          err,
    output logic [DATA_W-1:0]        rData,
    output logic                     memReq,
    output logic                     memWr,
    output logic [ADDR_W-1:0]        memAddr,
    output logic [DATA_W-1:0]        memDataIn,
    input  logic                     memBusy,
    input  logic [DATA_W-1:0]        memDataOut
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (ISSUE_TIMEOUT > 2) ? $clog2(ISSUE_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST =
        TW'((ISSUE_TIMEOUT > 0) ? ISSUE_TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     winner_q, winner_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              wr_q, wr_d;

    logic [IW-1:0]     pick;
    logic              pick_vld;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    mem_arbiter_rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req    (reqIn),
        .last   (last_q),
        .winner (pick),
        .valid  (pick_vld)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) begin
                sel_wr    = reqWr[i];
                sel_addr  = reqAddr[i*ADDR_W +: ADDR_W];
                sel_wdata = reqWData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        err_d    = '0;
        last_d   = last_q;
        winner_d = winner_q;
        timer_d  = timer_q;
        rdata_d  = rdata_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        req_d    = req_q;
        wr_d     = wr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    wr_d     = sel_wr;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    grant_d  = NREQ'(1) << pick;
                    winner_d = pick;
                    req_d    = 1'b1;
                    timer_d  = '0;
                    state_d  = ARB_ISSUE;
                end else begin
                    req_d = 1'b0;
                end
            end
            ARB_ISSUE: begin
                if (memBusy) begin
                    req_d   = 1'b0;
                    state_d = ARB_WAIT;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if ((ISSUE_TIMEOUT != 0) && (timer_q == T_LAST)) begin
                        req_d   = 1'b0;
                        err_d   = grant_q;
                        state_d = ARB_DONE;
                    end
                end
            end
            ARB_WAIT: begin
                if (!memBusy) begin
                    if (!wr_q) begin
                        rdata_d = memDataOut;
                    end
                    done_d  = grant_q;
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                // Gap cycle lets the memory return to idle before the next req.
                grant_d = '0;
                last_d  = winner_q;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            last_q   <= LAST_RST;
            winner_q <= '0;
            timer_q  <= '0;
            rdata_q  <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            timer_q  <= timer_d;
            rdata_q  <= rdata_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rData     = rdata_q;
    assign memReq    = req_q;
    assign memWr     = wr_q;
    assign memAddr   = addr_q;
    assign memDataIn = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: dummy memory, transaction-level model, directed tests.
module tb_mem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 8;
    localparam int TO   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   reqIn = '0;
    logic [NREQ-1:0]   reqWr = '0;
    logic [NREQ*AW-1:0] reqAddr = '0;
    logic [NREQ*DW-1:0] reqWData = '0;
    logic [NREQ-1:0]   grant, done, err;
    logic [DW-1:0]     rData;
    logic              memReq, memWr;
    logic [AW-1:0]     memAddr;
    logic [DW-1:0]     memDataIn;
    logic              memBusy;
    logic [DW-1:0]     memDataOut;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    mem_arbiter #(
        .NREQ          (NREQ),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .ISSUE_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reqIn      (reqIn),
        .reqWr      (reqWr),
        .reqAddr    (reqAddr),
        .reqWData   (reqWData),
        .grant      (grant),
        .done       (done),
        .err        (err),
        .rData      (rData),
        .memReq     (memReq),
        .memWr      (memWr),
        .memAddr    (memAddr),
        .memDataIn  (memDataIn),
        .memBusy    (memBusy),
        .memDataOut (memDataOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        return (i == 5) ? 8'hA5 : 8'((i * 7 + 3) & 255);
    endfunction

    // Dummy single-port memory: req -> busy, latency, data, ready gap.
    logic [7:0] mem_arr [256];
    int         rd_lat = 0;
    bit         dead = 1'b0;
    int         ms;
    int         mcnt;
    logic [7:0] m_la;
    logic       m_lw;
    logic [7:0] m_ld;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ms         <= 0;
            mcnt       <= 0;
            memBusy    <= 1'b0;
            memDataOut <= '0;
            m_la       <= '0;
            m_lw       <= 1'b0;
            m_ld       <= '0;
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_byte(i);
        end else begin
            case (ms)
                0: if (memReq && !dead) begin
                    memBusy <= 1'b1;
                    m_la    <= memAddr[7:0];
                    m_lw    <= memWr;
                    m_ld    <= memDataIn;
                    mcnt    <= rd_lat;
                    ms      <= 1;
                end
                1: if (mcnt == 0) begin
                    memBusy <= 1'b0;
                    if (m_lw) mem_arr[m_la] <= m_ld;
                    else memDataOut <= mem_arr[m_la];
                    ms <= 2;
                end else begin
                    mcnt <= mcnt - 1;
                end
                default: ms <= 0;
            endcase
        end
    end

    // Transaction-level reference model.
    function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
        int w;
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (w < 0 && ((r >> c) & 1) != 0) w = c;
        end
        return w;
    endfunction

    logic [NREQ-1:0] x_grant, x_done, x_err;
    logic [DW-1:0]   x_rdata, x_wdata;
    logic [AW-1:0]   x_addr;
    logic            x_req, x_wr;
    int              m_phase, m_owner, m_last, m_age, m_pick;
    logic [7:0]      ref_mem [256];

    always_comb m_pick = rr_next(reqIn, m_last);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            x_grant <= '0;
            x_done  <= '0;
            x_err   <= '0;
            x_rdata <= '0;
            x_wdata <= '0;
            x_addr  <= '0;
            x_req   <= 1'b0;
            x_wr    <= 1'b0;
            m_phase <= 0;
            m_owner <= 0;
            m_last  <= NREQ - 1;
            m_age   <= 0;
            for (int i = 0; i < 256; i++) ref_mem[i] <= init_byte(i);
        end else begin
            x_done <= '0;
            x_err  <= '0;
            case (m_phase)
                0: if (m_pick >= 0) begin
                    x_grant <= NREQ'(1) << m_pick;
                    x_req   <= 1'b1;
                    x_wr    <= reqWr[m_pick];
                    x_addr  <= reqAddr[m_pick*AW +: AW];
                    x_wdata <= reqWData[m_pick*DW +: DW];
                    m_owner <= m_pick;
                    m_age   <= 0;
                    m_phase <= 1;
                end
                1: if (memBusy) begin
                    x_req   <= 1'b0;
                    m_phase <= 2;
                end else if (TO != 0 && m_age + 1 == TO) begin
                    x_req   <= 1'b0;
                    x_err   <= x_grant;
                    m_phase <= 3;
                end else begin
                    m_age <= m_age + 1;
                end
                2: if (!memBusy) begin
                    x_done <= x_grant;
                    if (!x_wr) x_rdata <= ref_mem[x_addr[7:0]];
                    else ref_mem[x_addr[7:0]] <= x_wdata;
                    m_phase <= 3;
                end
                default: begin
                    x_grant <= '0;
                    m_last  <= m_owner;
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset && cmp_en) begin
            chk("grant", grant, x_grant);
            chk("done", done, x_done);
            chk("err", err, x_err);
            chk("rData", rData, x_rdata);
            chk("memReq", memReq, x_req);
            chk("memWr", memWr, x_wr);
            chk("memAddr", memAddr, x_addr);
            chk("memDataIn", memDataIn, x_wdata);
        end
    end

    task automatic set_req(input int r, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        reqWr[r]             = wr;
        reqAddr[r*AW +: AW]  = a;
        reqWData[r*DW +: DW] = d;
        reqIn[r]             = 1'b1;
    endtask

    task automatic wait_end(input logic [NREQ-1:0] mask, input int budget,
                            output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (((done | err) & mask) != 0) hit = 1'b1;
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_end: no done/err within %0d cycles", budget);
        end
    endtask

    task automatic wait_grant(input int budget, output logic [NREQ-1:0] g);
        int cyc;
        cyc = 0;
        g   = '0;
        while (g == '0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            g = grant;
        end
        if (g == '0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_grant: no grant within %0d cycles", budget);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int dn;
        logic [NREQ-1:0] g;

        #1 reset = 1'b1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_memReq", memReq, 0);
        chk("rst_rData", rData, 0);
        chk("rst_memAddr", memAddr, 0);
        idle(2);
        reset  = 1'b0;
        cmp_en = 1'b1;
        idle(1);

        // Single read of addr 5
        set_req(0, 1'b0, 32'd5, 8'h00);
        wait_end(2'b01, 50, cyc);
        chk("t1_latency", cyc, 4);
        chk("t1_done", done, 2'b01);
        chk("t1_grant", grant, 2'b01);
        chk("t1_rdata", rData, 8'hA5);
        reqIn = '0;
        idle(2);

        // Write 3C to addr 7 via req0, read it back via req1
        set_req(0, 1'b1, 32'd7, 8'h3C);
        wait_end(2'b01, 50, cyc);
        chk("t2_wr_done", done, 2'b01);
        chk("t2_wr_err", err, 2'b00);
        reqIn = '0;
        idle(2);
        set_req(1, 1'b0, 32'd7, 8'h00);
        wait_end(2'b10, 50, cyc);
        chk("t2_rd_done", done, 2'b10);
        chk("t2_rdata", rData, 8'h3C);
        reqIn = '0;
        idle(2);

        // Contention: both held, grants must alternate
        set_req(0, 1'b0, 32'd5, 8'h00);
        set_req(1, 1'b0, 32'd7, 8'h00);
        for (int t = 0; t < 4; t++) begin
            wait_grant(20, g);
            chk("t3_grant_seq", g, (t % 2 == 0) ? 2'b01 : 2'b10);
            wait_end(g, 50, cyc);
        end
        reqIn = '0;
        idle(3);

        // Memory latency 10
        rd_lat = 10;
        set_req(0, 1'b0, 32'd5, 8'h00);
        wait_end(2'b01, 60, cyc);
        chk("t4_latency", cyc, 14);
        chk("t4_rdata", rData, 8'hA5);
        reqIn = '0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done != '0) dn++;
        end
        chk("t4_extra_done", dn, 0);
        rd_lat = 0;

        // Issue timeout with a dead memory
        dead = 1'b1;
        set_req(1, 1'b0, 32'd9, 8'h00);
        wait_end(2'b10, 40, cyc);
        chk("t5_err_time", cyc, 17);
        chk("t5_err", err, 2'b10);
        chk("t5_no_done", done, 2'b00);
        reqIn = '0;
        idle(3);
        dead = 1'b0;

        // Reset while waiting on memory
        rd_lat = 10;
        set_req(0, 1'b0, 32'd7, 8'h00);
        wait_grant(20, g);
        idle(4);
        #2 reset = 1'b1;
        #1;
        chk("t6_grant", grant, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        chk("t6_memReq", memReq, 0);
        chk("t6_rData", rData, 0);
        set_req(0, 1'b0, 32'd5, 8'h00);
        set_req(1, 1'b0, 32'd7, 8'h00);
        @(negedge clk);
        chk("t6_hold_done", done, 0);
        reset  = 1'b0;
        rd_lat = 0;
        wait_grant(20, g);
        chk("t6_first_grant", g, 2'b01);
        wait_end(2'b01, 50, cyc);
        chk("t6_rdata", rData, 8'hA5);
        reqIn = '0;
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
